// File: rtl/exe_25.sv
// Enable-gated lamp blinker: while enabled, light_o is high for ON_CYCLES clocks
// then low for OFF_CYCLES clocks, repeating; disabled holds the lamp dark.
module exe_25 #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 25_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable_i,
    output logic light_o
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             light_q, light_d;

    // Next-state logic; the lamp value is computed alongside the state so it can be registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        light_d = light_q;
        if (!enable_i) begin
            // Disable discards any partial phase; re-enable always restarts with a full ON.
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            light_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ON;
                    cnt_d   = CNT_ZERO;
                    light_d = 1'b1;
                end
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = ST_OFF;
                        cnt_d   = CNT_ZERO;
                        light_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        light_d = 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cnt_q == OFF_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = CNT_ZERO;
                        light_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_ONE;
                        light_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    light_d = 1'b0;
                end
            endcase
        end
    end

    // State, phase counter and lamp register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            light_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            light_q <= light_d;
        end
    end

    assign light_o = light_q;

endmodule

// File: tb/tb_exe_25.sv
// Directed bench for exe_25: a 4/2 blinker and a 1/1 blinker share inputs and are
// scored each clock against a position-in-period reference model.
module tb_exe_25;

    logic clk;
    logic rst_n;
    logic enable;
    logic light_a;
    logic light_b;

    int checks = 0;
    int errors = 0;
    int pos    = -1;
    logic exp_a_q[$];
    logic exp_b_q[$];

    exe_25 #(.ON_CYCLES(4), .OFF_CYCLES(2)) u_dut_a (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .light_o  (light_a)
    );

    exe_25 #(.ON_CYCLES(1), .OFF_CYCLES(1)) u_dut_b (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .enable_i (enable),
        .light_o  (light_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive one clock of stimulus, predict both lamps, then score after the edge.
    task automatic cyc(input logic rst_v, input logic en_v, input string tag);
        logic ea, eb, obs_a, obs_b;
        rst_n  = rst_v;
        enable = en_v;
        if (!rst_v || !en_v) begin
            pos = -1;
            exp_a_q.push_back(1'b0);
            exp_b_q.push_back(1'b0);
        end else begin
            pos = pos + 1;
            exp_a_q.push_back((pos % 6) < 4);
            exp_b_q.push_back((pos % 2) < 1);
        end
        @(posedge clk);
        #1;
        ea    = exp_a_q.pop_front();
        eb    = exp_b_q.pop_front();
        obs_a = light_a;
        obs_b = light_b;
        checks++;
        assert (obs_a === ea) else begin
            errors++;
            $error("FAIL %s_4x2 pos=%0d: light_o=%b expected %b", tag, pos, obs_a, ea);
        end
        checks++;
        assert (obs_b === eb) else begin
            errors++;
            $error("FAIL %s_1x1 pos=%0d: light_o=%b expected %b", tag, pos, obs_b, eb);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Reset held with enable high: lamp stays dark.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, "reset");
        // Two full 111100 periods after release.
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, "blink");
        // Disable at clock 2 of an ON phase, hold disabled for 7 clocks.
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, "on_part");
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, "disable");
        // Re-enable: full ON phase then OFF.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, "reenable");
        // Reset for one clock while in OFF with enable high, then restart.
        cyc(1'b0, 1'b1, "rst_mid");
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, "post_rst");
        // Enable toggling every clock: lamp follows enable one clock later.
        for (int i = 0; i < 10; i++) cyc(1'b1, logic'(i % 2 == 0), "toggle");
        // Random enable with occasional reset.
        for (int i = 0; i < 80; i++)
            cyc(logic'($urandom_range(0, 15) != 0), logic'($urandom_range(0, 7) != 0), "random");

        checks++;
        assert (exp_a_q.size() == 0 && exp_b_q.size() == 0) else begin
            errors++;
            $error("FAIL drain: queue sizes %0d/%0d expected 0/0", exp_a_q.size(), exp_b_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
